// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: decode inputs, memory handshake and control outputs between controller and datapath
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_ctrl;
  logic       illegal;
  logic       timeout;
  logic [3:0] state;
  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal, timeout, state
  );
  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal, timeout, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing the multicycle RV32I-subset datapath
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 0,
  parameter int WAIT_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;
  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_cnt, w_cnt_inc;
  logic              r_timeout;
  logic              w_mem, w_expire, w_alu_ok;
  logic [2:0]        w_alu_dec, w_alu_ctrl;
  logic              w_mem_req, w_mem_write, w_ir_write, w_pc_write, w_reg_write, w_adr_src;
  logic [1:0]        w_result_src, w_src_a, w_src_b;
  assign w_mem     = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_expire  = (WAIT_LIMIT != 0) && w_mem && !bus.mem_ready && (w_cnt_inc == WAIT_W'(WAIT_LIMIT));
  // State, wait counter and sticky timeout flag; the counter only runs while a memory state is stalled
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_mem && !bus.mem_ready) ? w_cnt_inc : '0;
      if (w_expire) r_timeout <= 1'b1;
    end
  end
  // ALU operation from funct3; sub only for R-type with funct7b5, unsupported funct3 flagged
  always_comb begin
    w_alu_ok  = 1'b1;
    w_alu_dec = 3'b010;
    case (bus.funct3)
      3'b000:  w_alu_dec = (bus.op[5] && bus.funct7b5) ? 3'b110 : 3'b010;
      3'b010:  w_alu_dec = 3'b111;
      3'b110:  w_alu_dec = 3'b001;
      3'b111:  w_alu_dec = 3'b000;
      default: w_alu_ok  = 1'b0;
    endcase
  end
  // Next-state and Moore outputs; only the fetch strobes look at mem_ready
  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_alu_ctrl   = 3'b010;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
        w_next       = w_expire ? S_TRAP : bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_src_a = 2'b01;
        w_src_b = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = (bus.funct3 == 3'b000) ? S_BEQ : S_TRAP;
          7'b1101111:             w_next = S_JAL;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_src_a = 2'b10;
        w_src_b = 2'b01;
        w_next  = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        w_next    = w_expire ? S_TRAP : bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        w_next      = w_expire ? S_TRAP : bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        w_src_a    = 2'b10;
        w_src_b    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_alu_ctrl = w_alu_dec;
        w_next     = w_alu_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_src_a    = 2'b10;
        w_alu_ctrl = 3'b110;
        w_pc_write = bus.zero;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        w_src_a    = 2'b01;
        w_src_b    = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      default: w_next = S_TRAP;
    endcase
  end
  assign bus.mem_req    = w_mem_req & i_resetn;
  assign bus.mem_write  = w_mem_write & i_resetn;
  assign bus.ir_write   = w_ir_write & i_resetn;
  assign bus.pc_write   = w_pc_write & i_resetn;
  assign bus.reg_write  = w_reg_write & i_resetn;
  assign bus.adr_src    = w_adr_src;
  assign bus.result_src = w_result_src;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.alu_ctrl   = w_alu_ctrl;
  assign bus.illegal    = (r_state == S_TRAP);
  assign bus.timeout    = r_timeout & (r_state == S_TRAP);
  assign bus.state      = r_state;
  assign bus.imm_src    = (bus.op == 7'b0100011) ? 2'b01 :
                          (bus.op == 7'b1100011) ? 2'b10 :
                          (bus.op == 7'b1101111) ? 2'b11 : 2'b00;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared 32-bit ALU, register file, PC and unified memory of the multicycle RV32I-subset core. It decodes opcode and funct fields and drives the ALU operation code (000 and, 001 or, 010 add, 110 sub, 111 slt). It also drives operand muxes and write strobes, and stalls on memory handshakes. Supported instructions: lw, sw, R-type add/sub/and/or/slt, addi/andi/ori/slti, beq, jal; anything else traps.

Parameters:
WAIT_LIMIT, 0, max cycles to wait for mem_ready in a memory state; 0 = wait forever; nonzero = exceed -> TRAP with timeout=1
WAIT_W, 8, width of the wait counter; WAIT_LIMIT must be < 2^WAIT_W

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
op  input  7  instruction opcode (IR[6:0])
funct3  input  3  IR[14:12]
funct7b5  input  1  IR[30]
zero  input  1  ALU Zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_write  output  1  store enable, valid with mem_req
adr_src  output  1  0 = PC, 1 = ALUOut register
ir_write  output  1  latch IR/OldPC
pc_write  output  1  latch PC from result
reg_write  output  1  register file write
result_src  output  2  00 ALUOut reg, 01 memory data, 10 ALU result
alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4
imm_src  output  2  00 I, 01 S, 10 B, 11 J; decoded from op, combinational
alu_ctrl  output  3  ALU operation code
illegal  output  1  high in TRAP
timeout  output  1  high in TRAP if entered by wait expiry
state  output  4  current state for debug

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 15.
- resetn low: state = FETCH, wait counter = 0, timeout = 0, all strobes (mem_req, mem_write, ir_write, pc_write, reg_write) forced 0 combinationally. Release starts FETCH on the next edge.
- Default outputs: all strobes 0, muxes 00, alu_ctrl 010.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. ir_write and pc_write are 1 only when mem_ready=1. Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 with funct3=000 -> BEQ
  - 1101111 -> JAL
  - else TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, add. Goes to MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: mem_req=1, adr_src=1. Waits for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Waits for mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, then ALUWB.
- ALU decode (EXECR/EXECI), by funct3:
  - 000: sub (110) if op[5]=1 and funct7b5=1, else add (010)
  - 010: slt (111)
  - 110: or (001)
  - 111: and (000)
  - any other funct3: next state TRAP instead of ALUWB; no write occurs
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then ALUWB (rd = OldPC+4).
- TRAP: all strobes 0, illegal=1, absorbing until resetn.
- Wait counter: cleared on entry to any memory-wait state (FETCH, MEMREAD, MEMWRITE) and whenever mem_ready=1. Increments each cycle with mem_ready=0. If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT with mem_ready still 0, next state = TRAP and timeout=1.
- mem_ready asserted in a non-memory state is ignored.
- Reset mid-instruction aborts with no further strobes. Partially completed effects (e.g. PC already updated) are not undone.
- imm_src: op 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.

Test Plan:
- Reset then add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 -> states 0,1,6,8,0; alu_ctrl 010 in EXECR; reg_write only in ALUWB; total 4 cycles.
- sub (f7b5 1) and addi with IR[30]=1 -> sub gives alu_ctrl 110; addi gives 010 (no sub for I-type).
- lw with mem_ready low 3 cycles in MEMREAD -> mem_req/adr_src=1 held 4 cycles, then MEMWB with result_src 01 and reg_write; sw -> mem_write high until ready, no reg_write.
- beq with zero=1 and zero=0 -> pc_write 1 and 0 respectively in BEQ; jal -> pc_write in JAL, reg_write in following ALUWB.
- op 0000000, R-type f3 001, beq f3 001 -> TRAP, illegal=1, no strobes; WAIT_LIMIT=5 with mem_ready stuck 0 in FETCH -> TRAP after 5 cycles, timeout=1.
- resetn dropped in MEMWRITE -> mem_write falls immediately, state=0; release -> normal FETCH.
